// File: rtl/spi_master.sv
// SPI mode-0 master: one WIDTH-bit full-duplex word per transaction, MSB first,
// with programmable chip-select setup, hold and inter-transfer gap.
module spi_master #(
  parameter int WIDTH    = 8,  // must be >= 2
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] tx_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rx_data,
  output logic             sclk,
  output logic             mosi,
  input  logic             miso,
  output logic             ce0
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int CMAX = max2(max2(CLK_DIV, CS_SETUP), max2(CS_HOLD, CS_GAP));
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX + 1) : 1;
  localparam int BW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLD, GAP} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt, cnt_next, phase_len_m1;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] tx_sh, rx_sh;
  logic             phase_end, last_bit;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    phase_len_m1 = '0;
    case (state)
      SETUP:   phase_len_m1 = CW'(CS_SETUP - 1);
      LOW:     phase_len_m1 = CW'(CLK_DIV - 1);
      HIGH:    phase_len_m1 = CW'(CLK_DIV - 1);
      HOLD:    phase_len_m1 = CW'(CS_HOLD - 1);
      GAP:     phase_len_m1 = CW'(CS_GAP - 1);
      default: phase_len_m1 = '0;
    endcase
    phase_end = (cnt == phase_len_m1);
    last_bit  = (bit_cnt == BW'(WIDTH - 1));

    if (state == IDLE) begin
      cnt_next = '0;
      if (start) state_next = SETUP;
    end else if (phase_end) begin
      cnt_next = '0;
      case (state)
        SETUP:   state_next = LOW;
        LOW:     state_next = HIGH;
        HIGH:    state_next = last_bit ? HOLD : LOW;
        HOLD:    state_next = GAP;
        GAP:     state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end else begin
      cnt_next = cnt + CW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      rx_data <= '0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      ce0     <= 1'b1;
      bit_cnt <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          tx_sh   <= tx_data;
          mosi    <= tx_data[WIDTH-1];
          ce0     <= 1'b0;
          busy    <= 1'b1;
          bit_cnt <= '0;
        end
        LOW: if (phase_end) begin
          // miso is captured on the same edge that raises sclk
          sclk  <= 1'b1;
          rx_sh <= {rx_sh[WIDTH-2:0], miso};
        end
        HIGH: if (phase_end) begin
          sclk <= 1'b0;
          if (last_bit) begin
            bit_cnt <= '0;
          end else begin
            bit_cnt <= bit_cnt + BW'(1);
            mosi    <= tx_sh[WIDTH-2];
            tx_sh   <= {tx_sh[WIDTH-2:0], 1'b0};
          end
        end
        HOLD: if (phase_end) begin
          ce0     <= 1'b1;
          mosi    <= 1'b0;
          rx_data <= rx_sh;
          done    <= 1'b1;
        end
        GAP: if (phase_end) busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: table of single transfers (loopback and slave
// model), plus busy-start, back-to-back, mid-transfer reset and a wide/fast instance.
module tb_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, busy, done, sclk, mosi, miso, ce0;
  logic [7:0] tx_data, rx_data;
  bit         loop = 1'b1;

  logic        start_w, busy_w, done_w, sclk_w, mosi_w, ce0_w;
  logic [15:0] tx_w, rx_w;

  spi_master dut (
    .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .busy(busy),
    .done(done), .rx_data(rx_data), .sclk(sclk), .mosi(mosi), .miso(miso), .ce0(ce0)
  );

  spi_master #(.WIDTH(16), .CLK_DIV(1)) dut_w (
    .clk(clk), .rst(rst), .start(start_w), .tx_data(tx_w), .busy(busy_w),
    .done(done_w), .rx_data(rx_w), .sclk(sclk_w), .mosi(mosi_w), .miso(mosi_w), .ce0(ce0_w)
  );

  // Mode-0 slave model: preloads 8'h3C while deselected, shifts out on sclk fall.
  logic [7:0] slv_sh, slv_rx, slv_got;
  assign miso = loop ? mosi : slv_sh[7];
  always @(posedge ce0 or negedge sclk)
    if (ce0) slv_sh <= 8'h3C;
    else     slv_sh <= {slv_sh[6:0], 1'b0};
  always @(posedge sclk) slv_rx <= {slv_rx[6:0], mosi};
  always @(posedge ce0)  slv_got <= slv_rx;

  // Free-running monitors; tests take differences of snapshots.
  int unsigned busy_cyc = 0, ce0_cyc = 0, done_cnt = 0, rises = 0, hi_run = 0;
  int unsigned gaps[$];
  logic [7:0]  mosi_bits;
  always @(negedge clk) if (rst) begin
    if (busy) busy_cyc <= busy_cyc + 1;
    if (!ce0) ce0_cyc <= ce0_cyc + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (ce0) hi_run <= hi_run + 1;
    else if (hi_run != 0) begin
      gaps.push_back(hi_run);
      hi_run <= 0;
    end
  end
  always @(posedge sclk) begin
    rises     <= rises + 1;
    mosi_bits <= {mosi_bits[6:0], mosi};
  end

  int unsigned busy_w_cyc = 0, ce0_w_cyc = 0, done_w_cnt = 0, rises_w = 0;
  time         t_prev = 0, t_last = 0;
  always @(negedge clk) if (rst) begin
    if (busy_w) busy_w_cyc <= busy_w_cyc + 1;
    if (!ce0_w) ce0_w_cyc <= ce0_w_cyc + 1;
    if (done_w) done_w_cnt <= done_w_cnt + 1;
  end
  always @(posedge sclk_w) begin
    rises_w <= rises_w + 1;
    t_prev  <= t_last;
    t_last  <= $time;
  end

  int n_checks = 0, n_err = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  int unsigned s_busy, s_ce0, s_done, s_rises;
  int unsigned d_busy, d_ce0, d_done, d_rises;

  task automatic snap();
    s_busy = busy_cyc; s_ce0 = ce0_cyc; s_done = done_cnt; s_rises = rises;
  endtask

  task automatic delta();
    d_busy = busy_cyc - s_busy; d_ce0 = ce0_cyc - s_ce0;
    d_done = done_cnt - s_done; d_rises = rises - s_rises;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (!busy) begin ok = 1'b1; break; end
    end
    check(name, {31'd0, ok}, 32'd1);
  endtask

  // Accept happens on the posedge after start rises; tx_data is then scrambled.
  task automatic xfer(input logic [7:0] tx);
    @(negedge clk); #1;
    snap();
    start = 1'b1; tx_data = tx;
    @(negedge clk); #1;
    start = 1'b0; tx_data = ~tx;
    wait_idle("xfer_timeout");
    delta();
  endtask

  typedef struct {
    logic [7:0] tx;
    bit         loop;
    logic [7:0] exp_rx;
    logic [7:0] exp_slave;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 8'hA5, 8'h00};
    vecs[1] = '{8'hC3, 1'b0, 8'h3C, 8'hC3};
    vecs[2] = '{8'h5A, 1'b1, 8'h5A, 8'h00};
    vecs[3] = '{8'h00, 1'b1, 8'h00, 8'h00};
    vecs[4] = '{8'hFF, 1'b0, 8'h3C, 8'hFF};

    rst = 1'b0; start = 1'b0; tx_data = '0; start_w = 1'b0; tx_w = '0;
    #12;
    check("rst_sclk", {31'd0, sclk}, 32'd0);
    check("rst_mosi", {31'd0, mosi}, 32'd0);
    check("rst_ce0", {31'd0, ce0}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_rx", {24'd0, rx_data}, 32'd0);
    @(negedge clk); rst = 1'b1;

    // Defaults: ce0 low 2 + 2*8*4 + 2 = 68 cycles, busy 70.
    foreach (vecs[i]) begin
      loop = vecs[i].loop;
      xfer(vecs[i].tx);
      check($sformatf("v%0d_rx", i), {24'd0, rx_data}, {24'd0, vecs[i].exp_rx});
      check($sformatf("v%0d_mosi", i), {24'd0, mosi_bits}, {24'd0, vecs[i].tx});
      check($sformatf("v%0d_rises", i), d_rises, 32'd8);
      check($sformatf("v%0d_busy", i), d_busy, 32'd70);
      check($sformatf("v%0d_ce0", i), d_ce0, 32'd68);
      check($sformatf("v%0d_done", i), d_done, 32'd1);
      if (!vecs[i].loop)
        check($sformatf("v%0d_slave", i), {24'd0, slv_got}, {24'd0, vecs[i].exp_slave});
    end
    loop = 1'b1;

    // start with 8'hFF during an 8'h00 transfer must be ignored.
    @(negedge clk); #1;
    snap();
    start = 1'b1; tx_data = 8'h00;
    @(negedge clk); #1 start = 1'b0;
    repeat (8) @(negedge clk);
    #1 start = 1'b1; tx_data = 8'hFF;
    @(negedge clk); #1 start = 1'b0;
    wait_idle("ign_timeout");
    delta();
    check("ign_mosi", {24'd0, mosi_bits}, 32'd0);
    check("ign_rises", d_rises, 32'd8);
    check("ign_done", d_done, 32'd1);
    check("ign_rx", {24'd0, rx_data}, 32'd0);
    repeat (3) @(negedge clk);
    #1 check("ign_no_restart", {31'd0, busy}, 32'd0);

    // start held high: back-to-back transfers separated by CS_GAP+1 = 3 high cycles.
    begin
      int unsigned g0;
      bit ok;
      @(negedge clk); #1;
      snap();
      g0 = gaps.size();
      ok = 1'b0;
      start = 1'b1; tx_data = 8'h81;
      for (int i = 0; i < 400; i++) begin
        @(negedge clk); #1;
        if (done_cnt - s_done == 2) begin ok = 1'b1; break; end
      end
      check("b2b_timeout", {31'd0, ok}, 32'd1);
      start = 1'b0;
      wait_idle("b2b_idle_timeout");
      delta();
      check("b2b_done", d_done, 32'd2);
      check("b2b_rx", {24'd0, rx_data}, 32'h81);
      check("b2b_gap", (gaps.size() > g0 + 1) ? gaps[g0 + 1] : 32'd0, 32'd3);
    end

    // Async reset during the high phase of bit 4.
    begin
      bit ok = 1'b0;
      @(negedge clk); #1;
      snap();
      start = 1'b1; tx_data = 8'hA5;
      @(negedge clk); #1 start = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk); #1;
        if (rises - s_rises == 4 && sclk) begin ok = 1'b1; break; end
      end
      check("rst_mid_reach", {31'd0, ok}, 32'd1);
      #2 rst = 1'b0;
      #1;
      check("rst_mid_sclk", {31'd0, sclk}, 32'd0);
      check("rst_mid_ce0", {31'd0, ce0}, 32'd1);
      check("rst_mid_busy", {31'd0, busy}, 32'd0);
      check("rst_mid_rx", {24'd0, rx_data}, 32'd0);
      check("rst_mid_done", {31'd0, done}, 32'd0);
      @(negedge clk); #1 rst = 1'b1;
      repeat (5) @(negedge clk);
      #1 check("rst_mid_no_done", done_cnt - s_done, 32'd0);
      xfer(8'h3C);
      check("post_rst_rx", {24'd0, rx_data}, 32'h3C);
      check("post_rst_rises", d_rises, 32'd8);
      check("post_rst_done", d_done, 32'd1);
    end

    // WIDTH=16, CLK_DIV=1 loopback: ce0 low 2+32+2 = 36, busy 38, sclk period 20 ns.
    begin
      int unsigned sb, sc, sd, sr;
      bit ok = 1'b0;
      @(negedge clk); #1;
      sb = busy_w_cyc; sc = ce0_w_cyc; sd = done_w_cnt; sr = rises_w;
      start_w = 1'b1; tx_w = 16'h8001;
      @(negedge clk); #1 start_w = 1'b0; tx_w = 16'h0000;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk); #1;
        if (!busy_w) begin ok = 1'b1; break; end
      end
      check("w_timeout", {31'd0, ok}, 32'd1);
      check("w_rx", {16'd0, rx_w}, 32'h8001);
      check("w_rises", rises_w - sr, 32'd16);
      check("w_period", 32'(t_last - t_prev), 32'd20);
      check("w_busy", busy_w_cyc - sb, 32'd38);
      check("w_ce0", ce0_w_cyc - sc, 32'd36);
      check("w_done", done_w_cnt - sd, 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- SPI mode-0 master that drives the existing SPI slave interface (sclk, mosi, ce0, miso).
- Transfers one WIDTH-bit word per transaction, MSB first, full duplex.
- Sits between host logic (start/tx_data/rx_data handshake) and an off-block SPI slave. Generates sclk by dividing the system clock.

Parameters:
WIDTH, 8, bits per transaction
CLK_DIV, 4, system clk cycles per sclk half-period (>=1)
CS_SETUP, 2, clk cycles from ce0 fall to first sclk low phase start (>=1)
CS_HOLD, 2, clk cycles from final sclk fall to ce0 rise (>=1)
CS_GAP, 2, clk cycles ce0 held high after transfer before busy drops (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  request transfer; sampled only when busy=0
tx_data  input  WIDTH  word to send; captured on accepted start
busy  output  1  high from accepted start until end of gap
done  output  1  one-cycle pulse, rx_data valid
rx_data  output  WIDTH  last received word; held until next done
sclk  output  1  SPI clock, idles low
mosi  output  1  master out, slave in
miso  input  1  master in, slave out
ce0  output  1  active-low chip enable, idles high

Behaviour:
- Reset (rst=0, any time, async): state IDLE, sclk=0, mosi=0, ce0=1, busy=0, done=0, rx_data=0, shift/bit/divider counters cleared. A transfer in progress is abandoned; no done pulse.
- States: IDLE, SETUP, LOW, HIGH, HOLD, GAP.
- IDLE: start=1 at edge T0 moves to SETUP. At that edge: tx_data is latched into the tx shift reg, ce0=0, busy=1, mosi=tx_data[WIDTH-1]. tx_data changes after T0 have no effect.
- SETUP: lasts CS_SETUP cycles with sclk=0, then goes to LOW.
- LOW: lasts CLK_DIV cycles with sclk=0, then goes to HIGH. On the edge that sets sclk=1, miso is shifted into the rx shift reg LSB (left shift). miso is sampled on the same edge that raises sclk.
- HIGH: lasts CLK_DIV cycles with sclk=1. On the edge that leaves HIGH, sclk=0.
  - If bits remain, mosi advances to the next lower bit and the state goes to LOW.
  - After bit WIDTH (counter wraps WIDTH-1 -> 0), the state goes to HOLD; mosi is held.
- HOLD: lasts CS_HOLD cycles with sclk=0. On exit:
  - ce0=1, mosi=0
  - rx_data <= rx shift reg
  - done=1 for exactly one cycle
  - state goes to GAP
- GAP: lasts CS_GAP cycles with ce0=1. Then busy=0 and the state goes to IDLE.
- Timing:
  - ce0 is low for CS_SETUP + 2·WIDTH·CLK_DIV + CS_HOLD cycles.
  - busy is high for that count + CS_GAP cycles.
  - Exactly WIDTH rising sclk edges per transaction.
- start while busy=1 is ignored (not queued).
- start held high continuously: the next transfer is accepted on the first edge where busy=0 (IDLE), so ce0 stays high for >= CS_GAP+1 cycles between transfers.
- done and busy never both fall on the same edge: done precedes busy fall by CS_GAP cycles.
- Divider and bit counters are sized from CLK_DIV, CS_* and WIDTH via $clog2. No overflow is permitted at the maximum parameter values.

Test Plan:
- Loopback (miso tied to mosi), start with tx_data=8'hA5 -> mosi bits 1,0,1,0,0,1,0,1 on 8 sclk rises; rx_data=8'hA5 at done; busy high 70 cycles, ce0 low 68 cycles (defaults).
- Behavioural SPI slave model preloaded with 8'h3C, master sends 8'hC3 -> rx_data=8'h3C; slave receives 8'hC3 at ce0 rise.
- start pulsed at busy cycle 10 with tx_data=8'hFF during an 8'h00 transfer -> ignored; mosi stays 0; single done; exactly 8 sclk rises.
- start held high, tx_data=8'h81 -> back-to-back transfers; ce0 high exactly CS_GAP+1=3 cycles between them; one done per transfer.
- rst=0 asserted mid-bit 4 (sclk=1) -> same-instant sclk=0, ce0=1, busy=0, rx_data=0, no done; a fresh start afterwards completes normally.
- CLK_DIV=1, WIDTH=16, tx=16'h8001, loopback -> sclk period 2 clk, 16 rises, rx_data=16'h8001.
